// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: sequential fetch, latency-absorbing FIFO, epoch-tagged flush on redirect.
// Optional PREFETCH_STATS_EN adds saturating redirect and bubble counters.
module instr_prefetch #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        start_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     stall,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]              stat_redirects,
  output logic [15:0]              stat_bubbles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic              epoch;

  logic [31:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  // In-flight requests remember their epoch and address so responses can be tagged and filtered.
  logic              tag_epoch [DEPTH];
  logic [ADDR_W-1:0] tag_addr  [DEPTH];
  logic [PW-1:0]     tag_rd, tag_wr;
  logic [CW-1:0]     outstanding;

  logic running, flush, grant, resp, resp_live, pop;

  assign running   = (state == RUN);
  assign flush     = running && redirect;
  assign imem_req  = running && !redirect && ((int'(count) + int'(outstanding)) < DEPTH);
  assign imem_addr = fetch_addr;
  assign grant     = imem_req && imem_gnt;
  assign resp      = running && imem_rvalid && (outstanding != '0);
  assign resp_live = resp && !redirect && (tag_epoch[tag_rd] == epoch);
  assign pop       = running && !redirect && !stall && (count != '0);
  assign occupancy = count;

  always_comb begin
    instr       = NOP_INSTR;
    instr_valid = 1'b0;
    instr_pc    = '0;
    if (count != '0) begin
      instr       = fifo_data[rd_ptr];
      instr_valid = 1'b1;
      instr_pc    = fifo_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      epoch       <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
    end else begin
      case (state)
        IDLE: begin
          state      <= LOAD;
          fetch_addr <= start_pc;
        end
        LOAD:    state <= RUN;
        default: state <= RUN;
      endcase

      if (grant) begin
        fetch_addr <= fetch_addr + ADDR_W'(1);
        tag_wr     <= tag_wr + PW'(1);
      end
      if (resp)
        tag_rd <= tag_rd + PW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(resp);

      // Stale responses keep draining through the outstanding count; only the FIFO is cleared.
      if (flush) begin
        fetch_addr <= redirect_pc;
        epoch      <= ~epoch;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
      end else begin
        if (resp_live) wr_ptr <= wr_ptr + PW'(1);
        if (pop)       rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(resp_live) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      tag_epoch[tag_wr] <= epoch;
      tag_addr[tag_wr]  <= fetch_addr;
    end
    if (resp_live) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= tag_addr[tag_rd];
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_redirects <= '0;
      stat_bubbles   <= '0;
    end else begin
      if (flush && stat_redirects != 16'hFFFF)
        stat_redirects <= stat_redirects + 16'd1;
      if (running && !stall && count == '0 && stat_bubbles != 16'hFFFF)
        stat_bubbles <= stat_bubbles + 16'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_live && !pop && count == CW'(DEPTH)));
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(running && imem_rvalid && outstanding == '0));
  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= CW'(DEPTH));

endmodule
